regfile_access_seq: RTL and testbench

Single-port access sequencer that sits directly upstream of the windowed 72-entry register file. It accepts one instruction's register request (rs1, optional rs2, optional rd), serialises the reads onto the register file's single read/write port, and presents both operands to the ALU stage through a valid/ready handshake. It then waits for the result and issues the write-back to rd in the window that was current when the request was accepted.

---
 rtl/rf_seq_pkg.sv | 20 ++
 rtl/regfile_access_seq.sv | 193 +++++++++++++++++++
 tb/tb_regfile_access_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_seq_pkg.sv
// Shared types and widths for the register-file access sequencer.
package rf_seq_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_WIN_W  = 2;

    // r0 is hardwired to zero in the register file
    localparam logic [RF_ADDR_W-1:0] RF_R0 = '0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_A    = 3'd1,
        ST_RD_B    = 3'd2,
        ST_OPND    = 3'd3,
        ST_WAIT_WB = 3'd4,
        ST_WRITE   = 3'd5
    } rf_seq_state_e;

endpackage

// File: rtl/regfile_access_seq.sv
// Serialises one instruction's operand reads and its write-back onto the
// single port of the windowed register file.
// Optional feature: define RF_ZERO_SKIP_EN to skip port reads of r0 sources.
module regfile_access_seq
    import rf_seq_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Clr,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [RF_ADDR_W-1:0] req_rs1,
    input  logic [RF_ADDR_W-1:0] req_rs2,
    input  logic                 req_use_rs2,
    input  logic [RF_ADDR_W-1:0] req_rd,
    input  logic                 req_wr,
    input  logic [RF_WIN_W-1:0]  cwp,
    output logic                 opnd_valid,
    input  logic                 opnd_ready,
    output logic [RF_DATA_W-1:0] opnd_a,
    output logic [RF_DATA_W-1:0] opnd_b,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [RF_DATA_W-1:0] wb_data,
    output logic                 rf_enable,
    output logic                 rf_rw,
    output logic [RF_ADDR_W-1:0] rf_r_num,
    output logic [RF_WIN_W-1:0]  rf_window,
    output logic [RF_DATA_W-1:0] rf_in,
    input  logic [RF_DATA_W-1:0] rf_out
);

`ifdef RF_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    rf_seq_state_e        state_q, state_d;
    logic [RF_ADDR_W-1:0] rs2_q, rs2_d;
    logic                 use_rs2_q, use_rs2_d;
    logic [RF_ADDR_W-1:0] rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic [RF_WIN_W-1:0]  win_q, win_d;
    logic [RF_DATA_W-1:0] opnd_a_q, opnd_a_d;
    logic [RF_DATA_W-1:0] opnd_b_q, opnd_b_d;
    logic [RF_ADDR_W-1:0] rf_r_num_q, rf_r_num_d;
    logic [RF_WIN_W-1:0]  rf_window_q, rf_window_d;
    logic [RF_DATA_W-1:0] rf_in_q, rf_in_d;
    logic                 req_ready_q, req_ready_d;
    logic                 opnd_valid_q, opnd_valid_d;
    logic                 wb_ready_q, wb_ready_d;
    logic                 rf_enable_q, rf_enable_d;
    logic                 rf_rw_q, rf_rw_d;

    // Next-state, latch updates and port drive; flags decode the next state
    always_comb begin
        state_d      = state_q;
        rs2_d        = rs2_q;
        use_rs2_d    = use_rs2_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        win_d        = win_q;
        opnd_a_d     = opnd_a_q;
        opnd_b_d     = opnd_b_q;
        rf_r_num_d   = rf_r_num_q;
        rf_window_d  = rf_window_q;
        rf_in_d      = rf_in_q;
        req_ready_d  = 1'b0;
        opnd_valid_d = 1'b0;
        wb_ready_d   = 1'b0;
        rf_enable_d  = 1'b0;
        rf_rw_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rs2_d     = req_rs2;
                    use_rs2_d = req_use_rs2;
                    rd_d      = req_rd;
                    wr_d      = req_wr;
                    win_d     = cwp;
                    if (ZERO_SKIP && (req_rs1 == RF_R0)) begin
                        opnd_a_d = '0;
                        if (req_use_rs2 && !(req_rs2 == RF_R0)) begin
                            state_d     = ST_RD_B;
                            rf_r_num_d  = req_rs2;
                            rf_window_d = cwp;
                        end else begin
                            state_d  = ST_OPND;
                            opnd_b_d = '0;
                        end
                    end else begin
                        state_d     = ST_RD_A;
                        rf_r_num_d  = req_rs1;
                        rf_window_d = cwp;
                    end
                end
            end
            ST_RD_A: begin
                opnd_a_d = rf_out;
                if (use_rs2_q && !(ZERO_SKIP && (rs2_q == RF_R0))) begin
                    state_d    = ST_RD_B;
                    rf_r_num_d = rs2_q;
                end else begin
                    state_d  = ST_OPND;
                    opnd_b_d = '0;
                end
            end
            ST_RD_B: begin
                opnd_b_d = rf_out;
                state_d  = ST_OPND;
            end
            ST_OPND: begin
                if (opnd_ready) begin
                    state_d = (wr_q && (rd_q != RF_R0)) ? ST_WAIT_WB : ST_IDLE;
                end
            end
            ST_WAIT_WB: begin
                if (wb_valid) begin
                    state_d     = ST_WRITE;
                    rf_in_d     = wb_data;
                    rf_r_num_d  = rd_q;
                    rf_window_d = win_q;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        opnd_valid_d = (state_d == ST_OPND);
        wb_ready_d   = (state_d == ST_WAIT_WB);
        rf_enable_d  = (state_d == ST_RD_A) || (state_d == ST_RD_B) || (state_d == ST_WRITE);
        rf_rw_d      = (state_d == ST_WRITE);
    end

    // State and latch registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q      <= ST_IDLE;
            rs2_q        <= '0;
            use_rs2_q    <= 1'b0;
            rd_q         <= '0;
            wr_q         <= 1'b0;
            win_q        <= '0;
            opnd_a_q     <= '0;
            opnd_b_q     <= '0;
            rf_r_num_q   <= '0;
            rf_window_q  <= '0;
            rf_in_q      <= '0;
            req_ready_q  <= 1'b1;
            opnd_valid_q <= 1'b0;
            wb_ready_q   <= 1'b0;
            rf_enable_q  <= 1'b0;
            rf_rw_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rs2_q        <= rs2_d;
            use_rs2_q    <= use_rs2_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            win_q        <= win_d;
            opnd_a_q     <= opnd_a_d;
            opnd_b_q     <= opnd_b_d;
            rf_r_num_q   <= rf_r_num_d;
            rf_window_q  <= rf_window_d;
            rf_in_q      <= rf_in_d;
            req_ready_q  <= req_ready_d;
            opnd_valid_q <= opnd_valid_d;
            wb_ready_q   <= wb_ready_d;
            rf_enable_q  <= rf_enable_d;
            rf_rw_q      <= rf_rw_d;
        end
    end

    // Reset gates the handshake and the port enable immediately, so a write
    // in flight when Clr rises never reaches the register file
    assign req_ready  = req_ready_q & ~Clr;
    assign rf_enable  = rf_enable_q & ~Clr;
    assign opnd_valid = opnd_valid_q;
    assign wb_ready   = wb_ready_q;
    assign rf_rw      = rf_rw_q;
    assign opnd_a     = opnd_a_q;
    assign opnd_b     = opnd_b_q;
    assign rf_r_num   = rf_r_num_q;
    assign rf_window  = rf_window_q;
    assign rf_in      = rf_in_q;

endmodule

// File: tb/tb_regfile_access_seq.sv
// Bench for regfile_access_seq with a behavioural windowed register file.
// Honours RF_ZERO_SKIP_EN the same way as the design.
module tb_regfile_access_seq;

`ifdef RF_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Clr = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_rs1 = '0, req_rs2 = '0, req_rd = '0;
    logic        req_use_rs2 = 1'b0, req_wr = 1'b0;
    logic [1:0]  cwp = '0;
    logic        opnd_valid;
    logic        opnd_ready = 1'b0;
    logic [31:0] opnd_a, opnd_b;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [31:0] wb_data = '0;
    logic        rf_enable, rf_rw;
    logic [4:0]  rf_r_num;
    logic [1:0]  rf_window;
    logic [31:0] rf_in, rf_out;

    // Register file model storage, bench-side preload port and expected contents
    logic [31:0] mem  [4][32];
    logic [31:0] gold [4][32];
    logic        pre_en = 1'b0;
    logic [1:0]  pre_win = '0;
    logic [4:0]  pre_num = '0;
    logic [31:0] pre_data = '0;
    int          wr_count = 0;
    int          cyc = 0;

    int          checks = 0;
    int          errors = 0;
    int          last_accept = 0;
    logic [31:0] last_a = '0;
    bit          allow_stall = 1'b1;

    always #5 Clk = ~Clk;

    regfile_access_seq dut (
        .Clk(Clk), .Clr(Clr),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_use_rs2(req_use_rs2),
        .req_rd(req_rd), .req_wr(req_wr), .cwp(cwp),
        .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
        .opnd_a(opnd_a), .opnd_b(opnd_b),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .rf_enable(rf_enable), .rf_rw(rf_rw), .rf_r_num(rf_r_num),
        .rf_window(rf_window), .rf_in(rf_in), .rf_out(rf_out)
    );

    // Combinational read, r0 reads as zero
    assign rf_out = (rf_r_num == 5'd0) ? 32'd0 : mem[rf_window][rf_r_num];

    // Edge write when enabled for write; preload has priority during reset
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (pre_en) begin
            mem[pre_win][pre_num] <= pre_data;
        end else if (rf_enable && rf_rw) begin
            wr_count <= wr_count + 1;
            if (rf_r_num != 5'd0) mem[rf_window][rf_r_num] <= rf_in;
        end
    end

    // One full request: called just after a falling edge, returns just after one
    task automatic run_txn(input logic [4:0] rs1, input logic [4:0] rs2, input bit use2,
                           input logic [4:0] rd, input bit wr, input logic [1:0] win,
                           input logic [31:0] data, input bit clr_wr, input string tag);
        logic [31:0] ea, eb;
        logic [4:0]  seq [2];
        int          exp_reads, nreads, k, stall, wb0;
        bit          found, exp_wb;
        ea = (rs1 == 5'd0) ? 32'd0 : gold[win][rs1];
        eb = !use2 ? 32'd0 : ((rs2 == 5'd0) ? 32'd0 : gold[win][rs2]);
        exp_reads = 0;
        seq[0] = '0;
        seq[1] = '0;
        if (!SKIP || rs1 != 5'd0) begin seq[exp_reads] = rs1; exp_reads++; end
        if (use2 && (!SKIP || rs2 != 5'd0)) begin seq[exp_reads] = rs2; exp_reads++; end
        exp_wb = wr && (rd != 5'd0);
        wb0 = wr_count;

        req_rs1 = rs1; req_rs2 = rs2; req_use_rs2 = use2;
        req_rd = rd; req_wr = wr; cwp = win; req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL %s accept: req_ready=%b want 1", tag, req_ready); end
        @(posedge Clk);
        #1;
        last_accept = cyc;
        req_valid = 1'b0;
        cwp = win ^ 2'd1;

        nreads = 0; found = 1'b0; k = 0;
        while (!found && k < 16) begin
            @(negedge Clk);
            k++;
            if (opnd_valid === 1'b1) begin
                found = 1'b1;
            end else begin
                checks++;
                if (req_ready !== 1'b0) begin errors++; $display("FAIL %s busy_ready: req_ready=%b want 0", tag, req_ready); end
                if (rf_enable === 1'b1) begin
                    checks++;
                    if (nreads >= exp_reads || rf_rw !== 1'b0 || rf_r_num !== seq[nreads % 2] || rf_window !== win) begin
                        errors++;
                        $display("FAIL %s read_port #%0d: rw=%b num=%0d win=%0d want rw=0 num=%0d win=%0d (reads expected %0d)",
                                 tag, nreads, rf_rw, rf_r_num, rf_window, seq[nreads % 2], win, exp_reads);
                    end
                    nreads++;
                end
            end
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL %s opnd_timeout: opnd_valid=%b want 1 within 16 cycles", tag, opnd_valid);
            return;
        end
        checks++;
        if (k !== 1 + exp_reads) begin errors++; $display("FAIL %s opnd_latency: cycle N+%0d want N+%0d", tag, k, 1 + exp_reads); end
        checks++;
        if (nreads !== exp_reads) begin errors++; $display("FAIL %s read_count: %0d want %0d", tag, nreads, exp_reads); end
        checks++;
        if (opnd_a !== ea) begin errors++; $display("FAIL %s opnd_a: %h want %h", tag, opnd_a, ea); end
        checks++;
        if (opnd_b !== eb) begin errors++; $display("FAIL %s opnd_b: %h want %h", tag, opnd_b, eb); end
        last_a = opnd_a;

        stall = allow_stall ? $urandom_range(0, 2) : 0;
        repeat (stall) begin
            @(negedge Clk);
            checks++;
            if (opnd_valid !== 1'b1 || opnd_a !== ea || opnd_b !== eb) begin
                errors++;
                $display("FAIL %s opnd_hold: v=%b a=%h b=%h want v=1 a=%h b=%h", tag, opnd_valid, opnd_a, opnd_b, ea, eb);
            end
        end
        opnd_ready = 1'b1;
        @(posedge Clk);
        #1;
        opnd_ready = 1'b0;

        if (exp_wb) begin
            @(negedge Clk);
            checks++;
            if (wb_ready !== 1'b1 || opnd_valid !== 1'b0) begin
                errors++; $display("FAIL %s wait_wb: wb_ready=%b opnd_valid=%b want 1/0", tag, wb_ready, opnd_valid);
            end
            stall = allow_stall ? $urandom_range(0, 2) : 0;
            repeat (stall) begin
                @(negedge Clk);
                checks++;
                if (wb_ready !== 1'b1 || rf_enable !== 1'b0) begin
                    errors++; $display("FAIL %s wb_hold: wb_ready=%b rf_enable=%b want 1/0", tag, wb_ready, rf_enable);
                end
            end
            wb_data = data;
            wb_valid = 1'b1;
            @(posedge Clk);
            #1;
            wb_valid = 1'b0;
            wb_data = $urandom;
            @(negedge Clk);
            if (clr_wr) begin
                Clr = 1'b1;
                #1;
                checks++;
                if (rf_enable !== 1'b0) begin errors++; $display("FAIL %s clr_gate: rf_enable=%b want 0", tag, rf_enable); end
            end else begin
                checks++;
                if (rf_enable !== 1'b1 || rf_rw !== 1'b1 || rf_r_num !== rd || rf_window !== win || rf_in !== data) begin
                    errors++;
                    $display("FAIL %s write_port: en=%b rw=%b num=%0d win=%0d in=%h want 1 1 %0d %0d %h",
                             tag, rf_enable, rf_rw, rf_r_num, rf_window, rf_in, rd, win, data);
                end
            end
            @(posedge Clk);
            #1;
            if (clr_wr) Clr = 1'b0;
            else gold[win][rd] = data;
            @(negedge Clk);
            if (clr_wr) begin
                checks++;
                if (opnd_a !== 32'd0 || opnd_b !== 32'd0 || rf_r_num !== 5'd0 || rf_window !== 2'd0 ||
                    rf_in !== 32'd0 || opnd_valid !== 1'b0 || wb_ready !== 1'b0 || rf_rw !== 1'b0) begin
                    errors++;
                    $display("FAIL %s clr_values: a=%h b=%h num=%0d win=%0d in=%h v=%b wbr=%b rw=%b want all 0",
                             tag, opnd_a, opnd_b, rf_r_num, rf_window, rf_in, opnd_valid, wb_ready, rf_rw);
                end
            end
        end else begin
            @(negedge Clk);
            checks++;
            if (wb_ready !== 1'b0) begin errors++; $display("FAIL %s no_wb: wb_ready=%b want 0", tag, wb_ready); end
        end
        checks++;
        if (req_ready !== 1'b1 || rf_enable !== 1'b0) begin
            errors++; $display("FAIL %s back_idle: req_ready=%b rf_enable=%b want 1/0", tag, req_ready, rf_enable);
        end
        checks++;
        if ((wr_count - wb0) !== ((exp_wb && !clr_wr) ? 1 : 0)) begin
            errors++; $display("FAIL %s write_count: %0d want %0d", tag, wr_count - wb0, (exp_wb && !clr_wr) ? 1 : 0);
        end
    endtask

    // Preload all windows while held in reset, then check reset outputs
    task automatic test_reset();
        for (int w = 0; w < 4; w++) begin
            for (int r = 0; r < 32; r++) begin
                @(negedge Clk);
                pre_en = 1'b1;
                pre_win = 2'(w);
                pre_num = 5'(r);
                pre_data = (r == 0) ? 32'd0 : $urandom;
                gold[w][r] = pre_data;
            end
        end
        @(negedge Clk);
        pre_en = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || rf_enable !== 1'b0) begin
            errors++; $display("FAIL reset_hold: req_ready=%b rf_enable=%b want 0/0", req_ready, rf_enable);
        end
        checks++;
        if (opnd_valid !== 1'b0 || wb_ready !== 1'b0 || rf_rw !== 1'b0 || opnd_a !== 32'd0 || opnd_b !== 32'd0 ||
            rf_r_num !== 5'd0 || rf_window !== 2'd0 || rf_in !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: v=%b wbr=%b rw=%b a=%h b=%h num=%0d win=%0d in=%h want all 0",
                     opnd_valid, wb_ready, rf_rw, opnd_a, opnd_b, rf_r_num, rf_window, rf_in);
        end
        Clr = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release: req_ready=%b want 1", req_ready); end
        @(negedge Clk);
    endtask

    task automatic set_reg(input logic [1:0] w, input logic [4:0] r, input logic [31:0] v);
        Clr = 1'b1;
        pre_en = 1'b1; pre_win = w; pre_num = r; pre_data = v;
        gold[w][r] = v;
        @(negedge Clk);
        pre_en = 1'b0;
        Clr = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_read_both();
        set_reg(2'd1, 5'd17, 32'h0000_00AA);
        set_reg(2'd1, 5'd18, 32'h0000_0055);
        run_txn(5'd17, 5'd18, 1'b1, 5'd3, 1'b0, 2'd1, 32'd0, 1'b0, "read_both");
        checks++;
        if (last_a !== 32'h0000_00AA) begin errors++; $display("FAIL read_both_const: a=%h want 000000aa", last_a); end
    endtask

    task automatic test_immediate();
        set_reg(2'd0, 5'd5, 32'h0000_1234);
        run_txn(5'd5, 5'd7, 1'b0, 5'd0, 1'b0, 2'd0, 32'd0, 1'b0, "immediate");
    endtask

    task automatic test_wb_window();
        run_txn(5'd4, 5'd6, 1'b1, 5'd9, 1'b1, 2'd2, 32'hDEAD_BEEF, 1'b0, "wb_window");
        run_txn(5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 2'd2, 32'd0, 1'b0, "wb_readback");
        checks++;
        if (last_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wb_readback_const: a=%h want deadbeef", last_a); end
    endtask

    task automatic test_rd_zero();
        run_txn(5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 2'd3, 32'h5555_AAAA, 1'b0, "rd_zero");
    endtask

    task automatic test_clr_in_write();
        run_txn(5'd1, 5'd2, 1'b0, 5'd9, 1'b1, 2'd2, 32'h1234_5678, 1'b1, "clr_write");
        run_txn(5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 2'd2, 32'd0, 1'b0, "clr_readback");
        checks++;
        if (last_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL clr_target_kept: a=%h want deadbeef", last_a); end
    endtask

    task automatic test_zero_regs();
        run_txn(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 2'd1, 32'd0, 1'b0, "zero_both");
        run_txn(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd2, 32'd0, 1'b0, "zero_imm");
        run_txn(5'd0, 5'd18, 1'b1, 5'd0, 1'b0, 2'd1, 32'd0, 1'b0, "zero_rs1");
        run_txn(5'd17, 5'd0, 1'b1, 5'd0, 1'b0, 2'd1, 32'd0, 1'b0, "zero_rs2");
    endtask

    task automatic test_back_to_back();
        int first;
        allow_stall = 1'b0;
        run_txn(5'd3, 5'd4, 1'b1, 5'd0, 1'b0, 2'd0, 32'd0, 1'b0, "b2b_0");
        first = last_accept;
        run_txn(5'd5, 5'd6, 1'b1, 5'd0, 1'b0, 2'd3, 32'd0, 1'b0, "b2b_1");
        checks++;
        if (last_accept - first !== 4) begin errors++; $display("FAIL b2b_spacing: %0d cycles want 4", last_accept - first); end
        allow_stall = 1'b1;
    endtask

    task automatic test_random();
        logic [4:0] rs1, rs2, rd;
        for (int i = 0; i < 40; i++) begin
            rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rs2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            run_txn(rs1, rs2, 1'($urandom), rd, 1'($urandom), 2'($urandom), $urandom, 1'b0, "random");
        end
    endtask

    task automatic test_final_contents();
        for (int w = 0; w < 4; w++) begin
            for (int r = 1; r < 32; r++) begin
                checks++;
                if (mem[w][r] !== gold[w][r]) begin
                    errors++; $display("FAIL contents w%0d r%0d: %h want %h", w, r, mem[w][r], gold[w][r]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_both();
        test_immediate();
        test_wb_window();
        test_rd_zero();
        test_clr_in_write();
        test_zero_regs();
        test_back_to_back();
        test_random();
        test_final_contents();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
